// File: rtl/serial_arith_defs.sv
// rtl/serial_arith_defs.sv - shared FSM encodings for the bit-serial arithmetic blocks
package serial_arith_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } serial_state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - one-bit full subtractor cell, x - y - bin
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow out when y alone exceeds x, or when x == y and a borrow arrives.
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor with start/busy/done handshake
module serial_subtractor
    import serial_arith_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cell_d;
    logic             cell_bout;

    // The single cell always looks at the current LSBs and the carried borrow.
    full_subtractor_bit u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: capture on accepted start, one bit per SHIFT edge, single DONE cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                bin_d  = cell_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    borrow_d = cell_bout;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int P = W + 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int n_checks;
    int n_fail;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned full;
        full = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return W'(full);
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] d_o, output logic b_o,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 4 * P; i++) begin
            if (i > 1) begin
                @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
            end
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        d_o = diff;
        b_o = borrow;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, diff, borrow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{8'h5A, 8'h3C, 8'h00, 8'hFF, 8'h80};
        logic [W-1:0] vb [5] = '{8'h3C, 8'h5A, 8'h01, 8'hFF, 8'h00};
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        bit           bok;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], d, bo, lat, bok);
            n_checks++;
            if (lat != W + 1 || !bok) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: done at cycle %0d busy_ok=%0d, required cycle %0d busy_ok=1",
                         i, lat, bok, W + 1);
            end
            n_checks++;
            if (d !== ref_diff(va[i], vb[i]) || bo !== ref_borrow(va[i], vb[i])) begin
                n_fail++;
                $display("FAIL directed_result[%0d] %h-%h: diff=%h borrow=%b, required diff=%h borrow=%b",
                         i, va[i], vb[i], d, bo, ref_diff(va[i], vb[i]), ref_borrow(va[i], vb[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv, d;
        logic         bo;
        int           lat;
        bit           bok;
        for (int i = 0; i < 20; i++) begin
            av = W'($urandom);
            bv = (i % 5 == 0) ? av : W'($urandom);
            run_op(av, bv, d, bo, lat, bok);
            n_checks++;
            if (lat != W + 1 || d !== ref_diff(av, bv) || bo !== ref_borrow(av, bv)) begin
                n_fail++;
                $display("FAIL random[%0d] %h-%h: diff=%h borrow=%b lat=%0d, required diff=%h borrow=%b lat=%0d",
                         i, av, bv, d, bo, lat, ref_diff(av, bv), ref_borrow(av, bv), W + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] ea, eb;
        int           dones = 0;
        bit           timing_ok = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 3 * P; n++) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            if (n % P == 0) begin
                qa.push_back(a);
                qb.push_back(b);
            end
            @(negedge clk);
            if (done !== ((n % P) == W) || busy !== ((n % P) < W)) begin
                timing_ok = 1'b0;
                $display("cycle %0d: busy=%b done=%b unexpected", n, busy, done);
            end
            if (done === 1'b1) begin
                dones++;
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    n_checks++;
                    if (diff !== ref_diff(ea, eb) || borrow !== ref_borrow(ea, eb)) begin
                        n_fail++;
                        $display("FAIL b2b_result %h-%h: diff=%h borrow=%b, required diff=%h borrow=%b",
                                 ea, eb, diff, borrow, ref_diff(ea, eb), ref_borrow(ea, eb));
                    end
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (!timing_ok || dones != 3) begin
            n_fail++;
            $display("FAIL b2b_timing: done pulses=%0d timing_ok=%0d, required 3 and 1", dones, timing_ok);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        bit           bok;
        bit           saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'h17;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, diff, borrow} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow);
        end
        for (int i = 0; i < P + 2; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: activity after reset=1, required 0");
        end
        run_op(8'h10, 8'h01, d, bo, lat, bok);
        n_checks++;
        if (d !== 8'h0F || bo !== 1'b0 || lat != W + 1) begin
            n_fail++;
            $display("FAIL post_reset_op: diff=%h borrow=%b lat=%0d, required diff=0f borrow=0 lat=%0d",
                     d, bo, lat, W + 1);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        bit           bok;
        bit           stable = 1'b1;
        run_op(8'h5A, 8'h3C, d, bo, lat, bok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            if (diff !== 8'h1E || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                stable = 1'b0;
                $display("hold cycle %0d: diff=%h borrow=%b busy=%b done=%b", i, diff, borrow, busy, done);
            end
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL hold_stable: stable=0, required diff=1e borrow=0 busy=0 done=0 for 20 cycles");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
